fsab_req_sink: RTL and testbench

//  Target-side receive stage directly downstream of the FSAB arbiter output (fsabo_*).

---
 rtl/fsab_req_sink_pkg.sv | 35 +++
 rtl/fsab_sync_fifo.sv | 53 +++++
 rtl/fsab_req_sink.sv | 160 ++++++++++++++++
 tb/tb_fsab_req_sink.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsab_req_sink_pkg.sv
// Shared FSAB field widths, encodings, beat/header layouts and FSM state types.
package fsab_req_sink_pkg;

  localparam int FSAB_REQ_HI          = 0;
  localparam int FSAB_DID_HI          = 3;
  localparam int FSAB_ADDR_HI         = 30;
  localparam int FSAB_LEN_HI          = 3;
  localparam int FSAB_DATA_HI         = 63;
  localparam int FSAB_MASK_HI         = 7;
  localparam int FSAB_INITIAL_CREDITS = 4;
  localparam int FSAB_MAX_LEN         = 8;

  localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

  localparam logic [FSAB_LEN_HI:0] FSAB_LEN_ONE = {{FSAB_LEN_HI{1'b0}}, 1'b1};

  typedef struct packed {
    logic [FSAB_REQ_HI:0]  mode;
    logic [FSAB_DID_HI:0]  did;
    logic [FSAB_DID_HI:0]  subdid;
    logic [FSAB_ADDR_HI:0] addr;
    logic [FSAB_LEN_HI:0]  len;
  } hdr_t;

  typedef struct packed {
    logic [FSAB_DATA_HI:0] data;
    logic [FSAB_MASK_HI:0] mask;
    logic                  last;
  } wbeat_t;

  typedef enum logic {IN_IDLE, IN_WBEATS} in_state_t;
  typedef enum logic {OUT_HDR, OUT_WDATA} out_state_t;

endpackage

// File: rtl/fsab_sync_fifo.sv
// Synchronous FIFO, head read straight from storage flops (no input bypass: push at N visible at N+1).
// Push while full is dropped unless a pop frees the slot in the same cycle; pop while empty is ignored.
module fsab_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsab_req_sink.sv
// FSAB target receive stage: buffers arbitrated requests, re-presents them as header + write-data channels.
// Header push at N -> req_valid at N+1; retire at N -> fsabo_credit at N+1; backpressure by req_ready/wd_ready only.
module fsab_req_sink
  import fsab_req_sink_pkg::*;
#(
  parameter int HDR_DEPTH  = FSAB_INITIAL_CREDITS,
  parameter int MAX_LEN    = FSAB_MAX_LEN,
  parameter int DATA_DEPTH = HDR_DEPTH * MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fsabo_valid,
  input  logic [FSAB_REQ_HI:0]  fsabo_mode,
  input  logic [FSAB_DID_HI:0]  fsabo_did,
  input  logic [FSAB_DID_HI:0]  fsabo_subdid,
  input  logic [FSAB_ADDR_HI:0] fsabo_addr,
  input  logic [FSAB_LEN_HI:0]  fsabo_len,
  input  logic [FSAB_DATA_HI:0] fsabo_data,
  input  logic [FSAB_MASK_HI:0] fsabo_mask,
  output logic                  fsabo_credit,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [FSAB_REQ_HI:0]  req_mode,
  output logic [FSAB_DID_HI:0]  req_did,
  output logic [FSAB_DID_HI:0]  req_subdid,
  output logic [FSAB_ADDR_HI:0] req_addr,
  output logic [FSAB_LEN_HI:0]  req_len,
  output logic                  wd_valid,
  input  logic                  wd_ready,
  output logic [FSAB_DATA_HI:0] wd_data,
  output logic [FSAB_MASK_HI:0] wd_mask,
  output logic                  wd_last,
  output logic                  err_overflow,
  output logic                  err_badlen
);

  localparam logic [FSAB_LEN_HI:0] MAX_LEN_V = MAX_LEN[FSAB_LEN_HI:0];

  in_state_t              in_state;
  out_state_t             out_state;
  logic [FSAB_LEN_HI:0]   rem;
  logic                   credit_q;

  hdr_t                   hdr_din;
  hdr_t                   hdr_dout;
  wbeat_t                 dat_din;
  wbeat_t                 dat_dout;
  logic                   hdr_push, hdr_pop, hdr_full, hdr_empty;
  logic                   dat_push, dat_pop, dat_full, dat_empty;
  logic                   len_ok;
  logic                   is_write;
  logic                   retire;

  assign is_write = (fsabo_mode == FSAB_WRITE);
  assign len_ok   = (fsabo_len != '0) && (fsabo_len <= MAX_LEN_V);

  always_comb begin
    hdr_push     = 1'b0;
    dat_push     = 1'b0;
    hdr_din      = '{mode: fsabo_mode, did: fsabo_did, subdid: fsabo_subdid,
                     addr: fsabo_addr, len: fsabo_len};
    dat_din      = '{data: fsabo_data, mask: fsabo_mask, last: 1'b0};
    dat_din.last = (in_state == IN_IDLE) ? (fsabo_len == FSAB_LEN_ONE) : (rem == FSAB_LEN_ONE);
    if (fsabo_valid) begin
      if (in_state == IN_WBEATS) begin
        dat_push = 1'b1;
      end else if (!is_write) begin
        hdr_push = 1'b1;
      end else if (len_ok) begin
        hdr_push = 1'b1;
        dat_push = 1'b1;
      end
    end
  end

  fsab_sync_fifo #(.WIDTH($bits(hdr_t)), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hdr_push),
    .din   (hdr_din),
    .pop   (hdr_pop),
    .dout  (hdr_dout),
    .full  (hdr_full),
    .empty (hdr_empty)
  );

  fsab_sync_fifo #(.WIDTH($bits(wbeat_t)), .DEPTH(DATA_DEPTH)) u_dat_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dat_push),
    .din   (dat_din),
    .pop   (dat_pop),
    .dout  (dat_dout),
    .full  (dat_full),
    .empty (dat_empty)
  );

  assign req_valid = (out_state == OUT_HDR) & ~hdr_empty;
  assign wd_valid  = (out_state == OUT_WDATA) & ~dat_empty;
  assign hdr_pop   = req_valid & req_ready;
  assign dat_pop   = wd_valid & wd_ready;
  assign retire    = (hdr_pop & (hdr_dout.mode == FSAB_READ)) | (dat_pop & dat_dout.last);

  assign req_mode     = hdr_dout.mode;
  assign req_did      = hdr_dout.did;
  assign req_subdid   = hdr_dout.subdid;
  assign req_addr     = hdr_dout.addr;
  assign req_len      = hdr_dout.len;
  assign wd_data      = dat_dout.data;
  assign wd_mask      = dat_dout.mask;
  assign wd_last      = dat_dout.last;
  assign fsabo_credit = credit_q;

  // Input side: the FSM advances on every valid beat even when its push is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state     <= IN_IDLE;
      rem          <= '0;
      err_badlen   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if ((hdr_push & hdr_full & ~hdr_pop) | (dat_push & dat_full & ~dat_pop))
        err_overflow <= 1'b1;
      case (in_state)
        IN_IDLE: begin
          if (fsabo_valid && is_write) begin
            if (!len_ok) begin
              err_badlen <= 1'b1;
            end else if (fsabo_len != FSAB_LEN_ONE) begin
              in_state <= IN_WBEATS;
              rem      <= fsabo_len - 1'b1;
            end
          end
        end
        IN_WBEATS: begin
          if (fsabo_valid) begin
            rem <= rem - 1'b1;
            if (rem == FSAB_LEN_ONE) in_state <= IN_IDLE;
          end
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_HDR;
      credit_q  <= 1'b0;
    end else begin
      credit_q <= retire;
      case (out_state)
        OUT_HDR:   if (hdr_pop && hdr_dout.mode == FSAB_WRITE) out_state <= OUT_WDATA;
        OUT_WDATA: if (dat_pop && dat_dout.last) out_state <= OUT_HDR;
        default:   out_state <= OUT_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_fsab_req_sink.sv
// Bench for fsab_req_sink: transaction-level queue model compared every cycle, plus directed literal checks.
module tb_fsab_req_sink;
  import fsab_req_sink_pkg::*;

  localparam int HD = FSAB_INITIAL_CREDITS;
  localparam int ML = FSAB_MAX_LEN;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  fsabo_valid = 1'b0;
  logic [FSAB_REQ_HI:0]  fsabo_mode = '0;
  logic [FSAB_DID_HI:0]  fsabo_did = '0;
  logic [FSAB_DID_HI:0]  fsabo_subdid = '0;
  logic [FSAB_ADDR_HI:0] fsabo_addr = '0;
  logic [FSAB_LEN_HI:0]  fsabo_len = '0;
  logic [FSAB_DATA_HI:0] fsabo_data = '0;
  logic [FSAB_MASK_HI:0] fsabo_mask = '0;
  logic                  fsabo_credit;
  logic                  req_valid;
  logic                  req_ready = 1'b0;
  logic [FSAB_REQ_HI:0]  req_mode;
  logic [FSAB_DID_HI:0]  req_did;
  logic [FSAB_DID_HI:0]  req_subdid;
  logic [FSAB_ADDR_HI:0] req_addr;
  logic [FSAB_LEN_HI:0]  req_len;
  logic                  wd_valid;
  logic                  wd_ready = 1'b0;
  logic [FSAB_DATA_HI:0] wd_data;
  logic [FSAB_MASK_HI:0] wd_mask;
  logic                  wd_last;
  logic                  err_overflow;
  logic                  err_badlen;

  fsab_req_sink dut (
    .clk(clk), .rst(rst),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_did(req_did),
    .req_subdid(req_subdid), .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_mask(wd_mask),
    .wd_last(wd_last), .err_overflow(err_overflow), .err_badlen(err_badlen)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int credit_cnt = 0;
  logic rand_ready = 1'b0;

  // DUT-observed popped write beats, used by the directed literal checks
  logic [FSAB_DATA_HI:0] wd_log_data[$];
  logic                  wd_log_last[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as queues, per-transaction beat counters
  hdr_t   hq[$];
  wbeat_t dq[$];
  int     in_rem = 0;
  int     out_rem = 0;
  logic   exp_credit = 1'b0;
  logic   exp_ovf = 1'b0;
  logic   exp_bad = 1'b0;

  always @(negedge clk) begin
    logic exp_rv, exp_wv;
    hdr_t h;
    wbeat_t b;
    exp_rv = (out_rem == 0) && (hq.size() > 0);
    exp_wv = (out_rem > 0) && (dq.size() > 0);
    chk("req_valid", 128'(req_valid), 128'(exp_rv));
    chk("wd_valid", 128'(wd_valid), 128'(exp_wv));
    chk("fsabo_credit", 128'(fsabo_credit), 128'(exp_credit));
    chk("err_overflow", 128'(err_overflow), 128'(exp_ovf));
    chk("err_badlen", 128'(err_badlen), 128'(exp_bad));
    if (exp_rv && req_valid)
      chk("req_hdr", 128'({req_mode, req_did, req_subdid, req_addr, req_len}), 128'(hq[0]));
    if (exp_wv && wd_valid)
      chk("wd_beat", 128'({wd_data, wd_mask, wd_last}), 128'(dq[0]));
    if (fsabo_credit) credit_cnt++;
    if (wd_valid && wd_ready) begin
      wd_log_data.push_back(wd_data);
      wd_log_last.push_back(wd_last);
    end

    if (rst) begin
      hq.delete(); dq.delete();
      in_rem = 0; out_rem = 0;
      exp_credit = 1'b0; exp_ovf = 1'b0; exp_bad = 1'b0;
    end else begin
      exp_credit = 1'b0;
      if (exp_rv && req_ready) begin
        h = hq.pop_front();
        if (h.mode == FSAB_READ) exp_credit = 1'b1;
        else out_rem = int'(h.len);
      end else if (exp_wv && wd_ready) begin
        void'(dq.pop_front());
        out_rem--;
        if (out_rem == 0) exp_credit = 1'b1;
      end
      if (fsabo_valid) begin
        h = {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len};
        if (in_rem == 0) begin
          if (fsabo_mode == FSAB_READ) begin
            if (hq.size() < HD) hq.push_back(h); else exp_ovf = 1'b1;
          end else if (int'(fsabo_len) == 0 || int'(fsabo_len) > ML) begin
            exp_bad = 1'b1;
          end else begin
            if (hq.size() < HD) hq.push_back(h); else exp_ovf = 1'b1;
            b = {fsabo_data, fsabo_mask, (int'(fsabo_len) == 1)};
            if (dq.size() < HD * ML) dq.push_back(b); else exp_ovf = 1'b1;
            in_rem = int'(fsabo_len) - 1;
          end
        end else begin
          b = {fsabo_data, fsabo_mask, (in_rem == 1)};
          if (dq.size() < HD * ML) dq.push_back(b); else exp_ovf = 1'b1;
          in_rem--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) begin
      req_ready = ($urandom_range(0, 2) != 0);
      wd_ready  = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [FSAB_REQ_HI:0] mode, input logic [FSAB_ADDR_HI:0] addr,
                      input logic [FSAB_LEN_HI:0] len, input logic [FSAB_DATA_HI:0] data);
    fsabo_valid  = 1'b1;
    fsabo_mode   = mode;
    fsabo_did    = FSAB_DID_HI'($urandom);
    fsabo_subdid = FSAB_DID_HI'($urandom);
    fsabo_addr   = addr;
    fsabo_len    = len;
    fsabo_data   = data;
    fsabo_mask   = 8'($urandom);
    tick();
    fsabo_valid  = 1'b0;
  endtask

  task automatic wait_cred(input int c0, input int n, input int budget, input string name);
    int k = 0;
    while ((credit_cnt - c0) < n && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk(name, 128'(credit_cnt - c0), 128'(n));
  endtask

  initial begin
    int c0, started, k, len;
    logic [FSAB_DATA_HI:0] exp_d[4];
    exp_d[0] = 64'hA; exp_d[1] = 64'hB; exp_d[2] = 64'hC; exp_d[3] = 64'hD;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_valid", 128'(req_valid), 128'(0));
    chk("reset_wd_valid", 128'(wd_valid), 128'(0));
    chk("reset_credit", 128'(fsabo_credit), 128'(0));
    chk("reset_errs", 128'({err_overflow, err_badlen}), 128'(0));

    // 1: single read, header visible next cycle, credit one cycle after pop
    req_ready = 1'b1; wd_ready = 1'b1;
    tick();
    c0 = credit_cnt;
    beat(FSAB_READ, 31'h100, 4'd1, 64'h0);
    @(negedge clk);
    chk("t1_req_valid", 128'(req_valid), 128'(1));
    chk("t1_req_addr", 128'(req_addr), 128'h100);
    chk("t1_req_mode", 128'(req_mode), 128'(FSAB_READ));
    @(negedge clk);
    chk("t1_credit", 128'(fsabo_credit), 128'(1));
    @(negedge clk);
    chk("t1_credit_pulse", 128'(fsabo_credit), 128'(0));
    chk("t1_no_wd", 128'(wd_log_data.size()), 128'(0));
    wait_cred(c0, 1, 10, "t1_credits");

    // 2: write len=4, beats A..D in order, last only on D, one credit
    c0 = credit_cnt;
    wd_log_data.delete(); wd_log_last.delete();
    beat(FSAB_WRITE, 31'h200, 4'd4, 64'hA);
    for (int i = 1; i < 4; i++) beat(FSAB_WRITE, 31'h0, 4'd0, exp_d[i]);
    wait_cred(c0, 1, 30, "t2_credits");
    chk("t2_beats", 128'(wd_log_data.size()), 128'(4));
    for (int i = 0; i < 4 && i < wd_log_data.size(); i++) begin
      chk("t2_data", 128'(wd_log_data[i]), 128'(exp_d[i]));
      chk("t2_last", 128'(wd_log_last[i]), 128'(i == 3));
    end

    // 3: fill the header FIFO with the consumer stalled, then one beat too many
    req_ready = 1'b0;
    c0 = credit_cnt;
    for (int i = 0; i < HD; i++) beat(FSAB_READ, 31'(32'h300 + i), 4'd1, 64'h0);
    @(negedge clk);
    chk("t3_full_no_err", 128'(err_overflow), 128'(0));
    chk("t3_held", 128'(req_valid), 128'(1));
    beat(FSAB_READ, 31'h3FF, 4'd1, 64'h0);
    @(negedge clk);
    chk("t3_overflow", 128'(err_overflow), 128'(1));
    chk("t3_no_credit", 128'(credit_cnt - c0), 128'(0));
    req_ready = 1'b1;
    wait_cred(c0, HD, 30, "t3_credits");

    // 4: back-to-back write(2), read, write(1) under random stalls
    c0 = credit_cnt;
    rand_ready = 1'b1;
    beat(FSAB_WRITE, 31'h400, 4'd2, 64'h11);
    beat(FSAB_WRITE, 31'h0, 4'd0, 64'h22);
    beat(FSAB_READ, 31'h404, 4'd1, 64'h0);
    beat(FSAB_WRITE, 31'h408, 4'd1, 64'h33);
    wait_cred(c0, 3, 200, "t4_credits");
    rand_ready = 1'b0;
    tick();
    req_ready = 1'b1; wd_ready = 1'b1;

    // 5: illegal lengths are flagged and discarded; a read still works
    c0 = credit_cnt;
    beat(FSAB_WRITE, 31'h500, 4'd0, 64'h44);
    beat(FSAB_WRITE, 31'h504, 4'(ML + 1), 64'h55);
    @(negedge clk);
    chk("t5_badlen", 128'(err_badlen), 128'(1));
    chk("t5_no_push", 128'(req_valid), 128'(0));
    beat(FSAB_READ, 31'h508, 4'd1, 64'h0);
    wait_cred(c0, 1, 20, "t5_credits");

    // 6: reset in the middle of a write flushes everything
    wd_ready = 1'b0;
    beat(FSAB_WRITE, 31'h600, 4'd4, 64'h61);
    beat(FSAB_WRITE, 31'h0, 4'd0, 64'h62);
    rst = 1'b1;
    beat(FSAB_WRITE, 31'h0, 4'd0, 64'h63);
    rst = 1'b0;
    c0 = credit_cnt;
    @(negedge clk);
    chk("t6_outputs_zero", 128'({req_valid, wd_valid, fsabo_credit, err_overflow, err_badlen,
                                 req_addr, req_len, wd_data, wd_last}), 128'(0));
    wd_ready = 1'b1;
    beat(FSAB_READ, 31'h700, 4'd1, 64'h0);
    wait_cred(c0, 1, 20, "t6_credits");

    // Random traffic obeying the credit protocol
    rand_ready = 1'b1;
    c0 = credit_cnt;
    started = 0;
    for (int n = 0; n < 200; n++) begin
      k = 0;
      while ((HD - started + (credit_cnt - c0)) <= 0 && k < 500) begin
        tick();
        k++;
      end
      if (k >= 500) begin
        chk("rand_credit_wait", 128'(credit_cnt - c0), 128'(started));
        break;
      end
      if ($urandom_range(0, 19) == 0) begin
        beat(FSAB_WRITE, 31'($urandom), ($urandom_range(0, 1) != 0) ? 4'd0 : 4'(ML + 1), 64'($urandom));
      end else if ($urandom_range(0, 1) == 0) begin
        beat(FSAB_READ, 31'($urandom), 4'($urandom), 64'($urandom));
        started++;
      end else begin
        len = $urandom_range(1, ML);
        beat(FSAB_WRITE, 31'($urandom), 4'(len), {32'($urandom), 32'($urandom)});
        for (int i = 1; i < len; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          beat(FSAB_WRITE, 31'($urandom), 4'($urandom), {32'($urandom), 32'($urandom)});
        end
        started++;
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
    wait_cred(c0, started, 3000, "rand_drain_credits");
    rand_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
